// File: rtl/if_fetch.sv
`default_nettype none
// ============================================================================
// Module      : if_fetch
// Description : Instruction fetch stage of the MIPS pipeline. Owns the
//               program counter, drives a one-cycle registered-read
//               instruction memory and presents each fetched instruction to
//               decode with its PC and a valid flag. Stalls hold the current
//               instruction; a taken branch/jump costs one bubble cycle.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk_i          in   clock, all state changes on the rising edge
//   rst_n_i        in   synchronous active-low reset
//   stall_i        in   downstream cannot accept; hold current instruction
//   redirect_i     in   taken branch/jump this cycle (wins over stall)
//   redirect_pc_i  in   redirect target byte address
//   im_enable_o    out  instruction memory enable (low only in reset)
//   im_read_o      out  instruction memory read strobe
//   im_addr_o      out  instruction memory address (next fetch address)
//   im_data_i      in   instruction memory read data
//   instr_o        out  fetched instruction, NOP_INSTR when not valid
//   pc_o           out  byte address of instr_o
//   pc_plus4_o     out  pc_o + 4 (wraps)
//   valid_o        out  instr_o/pc_o hold a real in-path instruction
//   align_err_o    out  one-cycle pulse: misaligned redirect was aligned
//   instr_count_o  out  number of instructions accepted by decode
// ============================================================================
module if_fetch #(
    parameter int                      PC_SIZE    = 32,
    parameter int                      INSTR_SIZE = 32,
    parameter logic [PC_SIZE-1:0]      RESET_PC   = '0,
    parameter logic [INSTR_SIZE-1:0]   NOP_INSTR  = '0
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic                    stall_i,
    input  logic                    redirect_i,
    input  logic [PC_SIZE-1:0]      redirect_pc_i,
    output logic                    im_enable_o,
    output logic                    im_read_o,
    output logic [PC_SIZE-1:0]      im_addr_o,
    input  logic [INSTR_SIZE-1:0]   im_data_i,
    output logic [INSTR_SIZE-1:0]   instr_o,
    output logic [PC_SIZE-1:0]      pc_o,
    output logic [PC_SIZE-1:0]      pc_plus4_o,
    output logic                    valid_o,
    output logic                    align_err_o,
    output logic [31:0]             instr_count_o
);

    localparam logic [1:0]          c_BOOT   = 2'd0;
    localparam logic [1:0]          c_RUN    = 2'd1;
    localparam logic [1:0]          c_BUBBLE = 2'd2;
    localparam logic [PC_SIZE-1:0]  c_PC_INC = PC_SIZE'(4);

    logic [1:0]          r_state;
    logic [PC_SIZE-1:0]  r_fetch_pc;   // address being read from im this cycle
    logic [PC_SIZE-1:0]  r_req_pc;     // address whose data im currently holds
    logic                r_align_err;
    logic [31:0]         r_instr_count;

    logic                w_valid;
    logic                w_accept;

    assign w_valid  = (r_state == c_RUN);
    assign w_accept = w_valid & ~stall_i;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_state       <= c_BOOT;
            r_fetch_pc    <= RESET_PC;
            r_req_pc      <= RESET_PC;
            r_align_err   <= 1'b0;
            r_instr_count <= 32'd0;
        end else begin
            r_align_err <= redirect_i & (|redirect_pc_i[1:0]);

            if (w_accept) begin
                r_instr_count <= r_instr_count + 32'd1;
            end

            if (redirect_i) begin
                // Whatever im returns for this edge is wrong-path; BUBBLE
                // keeps it off the outputs while the target is read.
                r_fetch_pc <= {redirect_pc_i[PC_SIZE-1:2], 2'b00};
                r_state    <= c_BUBBLE;
            end else if (!stall_i) begin
                r_req_pc   <= r_fetch_pc;
                r_fetch_pc <= r_fetch_pc + c_PC_INC;
                r_state    <= c_RUN;
            end
        end
    end

    // Enable low in reset clears im's output register; read low with
    // enable high makes im hold its data across a stall.
    assign im_enable_o   = rst_n_i;
    assign im_read_o     = rst_n_i & ~stall_i;
    assign im_addr_o     = r_fetch_pc;

    assign valid_o       = w_valid;
    assign instr_o       = w_valid ? im_data_i : NOP_INSTR;
    assign pc_o          = r_req_pc;
    assign pc_plus4_o    = r_req_pc + c_PC_INC;
    assign align_err_o   = r_align_err;
    assign instr_count_o = r_instr_count;

endmodule
`default_nettype wire

// File: doc/if_fetch.md
# if_fetch

Instruction fetch stage of the MIPS pipeline. Owns the program counter and drives the instruction memory (`im`), which has a one-cycle registered read. Presents each fetched instruction to decode with its PC and a valid flag. Honours decode/hazard stalls and branch/jump redirects, with one bubble per taken redirect.

## Interface
- `RESET_PC`, 32'h0000_0000: byte address fetched first after reset.
- `NOP_INSTR`, 32'h0000_0000: value driven on `instr_o` when `valid_o`=0.
- `clk_i` in 1: single clock; all state changes on the `EDGE_OPERATE` edge.
- `rst_n_i` in 1: reset; synchronous, active-low.
- `stall_i` in 1: downstream cannot accept; hold the current instruction.
- `redirect_i` in 1: taken branch/jump this cycle.
- `redirect_pc_i` in `PC_SIZE`: redirect target, byte address.
- `im_enable_o` out 1: to `im.enable_i`.
- `im_read_o` out 1: to `im.read_i`.
- `im_addr_o` out `PC_SIZE`: to `im.addr_i`; always equals `fetch_pc`.
- `im_data_i` in `INSTR_SIZE`: from `im.data_o`.
- `instr_o` out `INSTR_SIZE`: fetched instruction; `NOP_INSTR` when not valid.
- `pc_o` out `PC_SIZE`: byte address of `instr_o`.
- `pc_plus4_o` out `PC_SIZE`: `pc_o + 4`, mod 2^32.
- `valid_o` out 1: `instr_o`/`pc_o` are a real, in-path instruction.
- `align_err_o` out 1: one-cycle pulse when a misaligned redirect target was forced aligned.
- `instr_count_o` out 32: number of instructions accepted by decode.

## Operation
- Registers: `fetch_pc` (next address to read), `req_pc` (address whose data `im` currently holds), `state` ∈ {BOOT, RUN, BUBBLE}, `instr_count`.
- `im_write` is never driven; this stage only reads.
- `im_enable_o` = 1 except during reset, when it is 0. This makes `im` clear its output.
- `im_read_o` = 1 when out of reset and `stall_i`=0, otherwise 0. With read low and enable high, `im` holds its data.
- Non-stalled edge with no redirect:
  - `req_pc <= fetch_pc`.
  - `fetch_pc <= fetch_pc + 4`, wrapping 32'hFFFF_FFFC → 0.
  - BOOT→RUN, BUBBLE→RUN, RUN→RUN.
- Stalled edge with no redirect: `fetch_pc`, `req_pc` and `state` all hold. Outputs stay bit-stable.
- Redirect edge (priority over stall):
  - `fetch_pc <= {redirect_pc_i[31:2], 2'b00}`.
  - `state <= BUBBLE`. The instruction in flight that edge is wrong-path and is discarded.
  - `align_err_o` is 1 the following cycle if `redirect_pc_i[1:0]` != 0, otherwise 0.
- Outputs:
  - `valid_o` = (`state`==RUN).
  - `instr_o` = `valid_o` ? `im_data_i` : `NOP_INSTR`.
  - `pc_o` = `req_pc`; `pc_plus4_o` = `req_pc + 4`.
- Acceptance: decode takes an instruction on an edge with `valid_o`=1 and `stall_i`=0. On that edge `instr_count` increments, wrapping at 2^32.
- Reset (`rst_n_i`=0 at an edge), including mid-operation, any state or pending redirect:
  - `fetch_pc <= RESET_PC`, `req_pc <= RESET_PC`, `state <= BOOT`, `instr_count <= 0`.
  - Any in-flight fetch is dropped.

## Timing
- Reset values of outputs: `valid_o`=0, `instr_o`=`NOP_INSTR`, `pc_o`=`RESET_PC`, `pc_plus4_o`=`RESET_PC+4`, `align_err_o`=0, `instr_count_o`=0, `im_enable_o`=0, `im_read_o`=0, `im_addr_o`=`RESET_PC`.
- Fetch latency: address driven in cycle n; instruction valid on outputs in cycle n+1.
- Startup: first cycle after reset release is BOOT (`valid_o`=0, reading `RESET_PC`). `RESET_PC` is presented valid one cycle later.
- Redirect penalty: exactly one bubble cycle.
  - Redirect sampled at edge k; cycle k is BUBBLE (`valid_o`=0) and reads the target.
  - Target instruction is valid in cycle k+1.
- Stall during BOOT or BUBBLE: state holds and no read is issued. Remaining in BOOT/BUBBLE costs no extra fetch.
- Back-to-back redirects: each one re-arms BUBBLE; only the last target is fetched.
- `redirect_i` with `stall_i`=1 in RUN:
  - The held instruction is dropped.
  - `valid_o`=0 next cycle, while stall persists.
  - The target is fetched on the first unstalled cycle and valid the cycle after.

## Test plan
- Reset then run, with `im` loaded words 0..7 = 0x100+i and `RESET_PC`=0:
  - `valid_o`=0 for 1 cycle after release.
  - Then `pc_o` = 0, 4, 8, … with `instr_o` = 0x100, 0x101, … one per cycle.
  - `instr_count_o` increments each cycle.
- Stall `stall_i`=1 for 3 cycles while presenting pc 8:
  - `instr_o`=0x102, `pc_o`=8 stable, `im_read_o`=0, `instr_count_o` frozen.
  - Release → pc 12 next cycle.
- Redirect to 0x40 while presenting pc 4:
  - Next cycle `valid_o`=0.
  - The following cycle `pc_o`=0x40 with `instr_o`=mem[16].
  - `instr_count_o` excludes the discarded instruction.
- Redirect with stall asserted, plus misaligned target: `redirect_pc_i`=0x43 with `stall_i`=1.
  - `align_err_o`=1 for one cycle, `valid_o`=0.
  - After stall drops, `pc_o`=0x40 one cycle later.
- Wrap: redirect to 0xFFFF_FFFC (stub `im_data_i`).
  - `pc_o`=0xFFFF_FFFC, `pc_plus4_o`=0, next `pc_o`=0.
- Reset asserted mid-stream and mid-BUBBLE:
  - All outputs return to reset values at the next edge.
  - Sequence restarts at `RESET_PC` with a BOOT cycle.
